// File: rtl/sd_dat_pkg.sv
// Shared SD DAT path definitions.
// Used by the FIFO and by the DAT P/S and S/P stages.
package sd_dat_pkg;
  localparam int DAT_W      = 32;
  localparam int FIFO_DEPTH = 8;

  typedef logic [DAT_W-1:0] dat_word_t;
endpackage

// File: rtl/sd_dat_fifo_mem.sv
// DEPTH x DAT_W register file for the DAT FIFO.
// One synchronous write port and one asynchronous read port; contents are never reset.
module sd_dat_fifo_mem
  import sd_dat_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  dat_word_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output dat_word_t     rd_data
);

  dat_word_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read gives first-word fall-through at the FIFO head.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sd_dat_fifo.sv
// SD DAT path FIFO between the serial-to-parallel and parallel-to-serial stages.
// Define SD_DAT_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sd_dat_fifo
  import sd_dat_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  dat_word_t                toFifo_fromSP,
  input  logic                     pop,
  output dat_word_t                fromFifo_toPS,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_afull,
  output logic [$clog2(DEPTH):0]   count
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc;
  logic          pop_acc;
  logic          mem_wr_en;

  // Status is decoded from the registered count only, so push/pop never reach it.
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_afull = (count_q >= CW'(AFULL_LVL));
  assign count      = count_q;

  assign pop_acc   = pop && !fifo_empty;
  assign push_acc  = push && (!fifo_full || pop_acc);
  assign mem_wr_en = push_acc && !flush && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + CW'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset; flush deliberately leaves them alone.
  always_comb begin
    overflow_d  = overflow_q | (push && !push_acc);
    underflow_d = underflow_q | (pop && !pop_acc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  sd_dat_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (toFifo_fromSP),
    .rd_addr (rd_ptr_q),
    .rd_data (fromFifo_toPS)
  );

endmodule

// File: tb/tb_sd_dat_fifo.sv
// Self-checking bench for sd_dat_fifo against a queue-based reference model.
// Overflow/underflow checks compile in when SD_DAT_FIFO_ERR_FLAGS_EN is defined.
module tb_sd_dat_fifo;
  import sd_dat_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;

  logic        clock = 1'b0;
  logic        reset, flush, push, pop;
  dat_word_t   din, dout;
  logic        fifo_full, fifo_empty, fifo_afull;
  logic [3:0]  count;
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
  logic        ovf_m, unf_m;
`endif

  dat_word_t   q[$];
  int          errors = 0;
  int          checks = 0;
  dat_word_t   fill_words [8];

  always #5 clock = ~clock;

  sd_dat_fifo dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .push          (push),
    .toFifo_fromSP (din),
    .pop           (pop),
    .fromFifo_toPS (dout),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_afull    (fifo_afull),
    .count         (count)
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"},  32'(fifo_full),  32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, ".afull"}, 32'(fifo_afull), 32'(q.size() >= AFULL));
    if (q.size() > 0) chk({tag, ".head"}, dout, q[0]);
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 32'(overflow),  32'(ovf_m));
    chk({tag, ".unf"}, 32'(underflow), 32'(unf_m));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, check #1 later.
  task automatic cycle(input string tag, input logic rst_i, input logic fl_i,
                       input logic psh_i, input logic pp_i, input dat_word_t d_i);
    bit pop_ok, push_ok;
    reset = rst_i; flush = fl_i; push = psh_i; pop = pp_i; din = d_i;
    @(posedge clock);
    pop_ok  = pp_i && (q.size() > 0);
    push_ok = psh_i && ((q.size() < DEPTH) || pop_ok);
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
    if (rst_i) begin
      ovf_m = 1'b0; unf_m = 1'b0;
    end else begin
      if (psh_i && !push_ok) ovf_m = 1'b1;
      if (pp_i && !pop_ok)   unf_m = 1'b1;
    end
`endif
    if (rst_i || fl_i) begin
      q.delete();
    end else begin
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d_i);
    end
    #1;
    $display("%0t %s rst=%0b fl=%0b push=%0b pop=%0b din=%h -> count=%0d head=%h",
             $time, tag, rst_i, fl_i, psh_i, pp_i, d_i, count, dout);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
`ifdef SD_DAT_FIFO_ERR_FLAGS_EN
    ovf_m = 1'b0; unf_m = 1'b0;
`endif
    fill_words[0] = 32'hC000_0003; fill_words[1] = 32'hC000_E000;
    fill_words[2] = 32'hC00F_0001; fill_words[3] = 32'hC0A0_5A5A;
    fill_words[4] = 32'hC123_4567; fill_words[5] = 32'hC89A_BCDE;
    fill_words[6] = 32'hC000_0FF0; fill_words[7] = 32'hCFFF_FFFC;

    cycle("reset", 1, 0, 0, 0, '0);
    cycle("reset", 1, 0, 0, 0, '0);
    chk("reset.empty", 32'(fifo_empty), 32'd1);
    chk("reset.count", 32'(count), 32'd0);

    // Fill to full; afull must rise after the 6th push.
    for (int i = 0; i < 8; i++) begin
      cycle("fill", 0, 0, 1, 0, fill_words[i]);
      if (i == 5) begin
        chk("afull.flag", 32'(fifo_afull), 32'd1);
        chk("afull.count", 32'(count), 32'd6);
      end
    end
    chk("fill.full", 32'(fifo_full), 32'd1);

    // Full with simultaneous push and pop.
    cycle("fullpp", 0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("fullpp.count", 32'(count), 32'd8);
    chk("fullpp.head", dout, fill_words[1]);
    cycle("ovf", 0, 0, 1, 0, 32'h1111_2222);
    chk("ovf.count", 32'(count), 32'd8);

    // Drain; the 8th word read must be DEADBEEF.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("drain.last", dout, 32'hDEAD_BEEF);
      cycle("drain", 0, 0, 0, 1, '0);
    end
    chk("drain.empty", 32'(fifo_empty), 32'd1);

    cycle("unf", 0, 0, 0, 1, '0);
    cycle("unf", 0, 0, 0, 1, '0);
    cycle("after_unf", 0, 0, 1, 0, 32'h0BAD_F00D);
    cycle("after_unf", 0, 0, 0, 1, '0);
    cycle("empty_pp", 0, 0, 1, 1, 32'h5555_AAAA);
    chk("empty_pp.count", 32'(count), 32'd1);
    cycle("empty_pp", 0, 0, 0, 1, '0);

    // Flush with push, then reset with push, each from 3 stored words.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) cycle("load3", 0, 0, 1, 0, $urandom);
      if (r == 0) cycle("flush", 0, 1, 1, 0, 32'h7777_7777);
      else        cycle("rst_mid", 1, 0, 1, 0, 32'h8888_8888);
      chk("clear.count", 32'(count), 32'd0);
      chk("clear.empty", 32'(fifo_empty), 32'd1);
      cycle("post_clear", 0, 0, 1, 0, 32'h600D_0000 + 32'(r));
      chk("post_clear.head", dout, 32'h600D_0000 + 32'(r));
      cycle("post_clear", 0, 0, 0, 1, '0);
    end

    // Wrap: steady occupancy of 2 across 20 push/pop pairs.
    cycle("wrap_pre", 0, 0, 1, 0, 32'hA000_0000);
    cycle("wrap_pre", 0, 0, 1, 0, 32'hA000_0001);
    for (int i = 0; i < 20; i++) cycle("wrap", 0, 0, 1, 1, 32'hB000_0000 + 32'(i));
    chk("wrap.count", 32'(count), 32'd2);

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 0, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_dat_fifo.md
SD_DAT_FIFO -- requirements
Module: sd_dat_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of 32-bit entries; power of two, at least 4.
REQ-002 Parameter AFULL_LVL, default DEPTH-2, occupancy at which fifo_afull asserts.
REQ-003 clock  in  1  single block clock; every register samples on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous clear of contents, used between SD services.
REQ-006 push  in  1  write request from the DAT serial-to-parallel stage.
REQ-007 toFifo_fromSP  in  32  write data, sampled when push is accepted.
REQ-008 pop  in  1  read request from the DAT parallel-to-serial stage.
REQ-009 fromFifo_toPS  out  32  head entry, first-word fall-through.
REQ-010 fifo_full  out  1  occupancy == DEPTH.
REQ-011 fifo_empty  out  1  occupancy == 0.
REQ-012 fifo_afull  out  1  occupancy >= AFULL_LVL.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow, underflow  out  1 each  sticky error flags; present only with the macro in REQ-030.

Function
REQ-015 Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 with no special case.
REQ-016 A push is accepted when push=1 and (fifo_full=0 or pop is accepted in the same cycle); the word is written at wr_ptr and wr_ptr increments.
REQ-017 A pop is accepted when pop=1 and fifo_empty=0; rd_ptr increments.
REQ-018 fromFifo_toPS is mem[rd_ptr] at all times: a written word is visible on the cycle after the push edge, and a pop exposes the next word on the cycle after the pop edge.
REQ-019 fromFifo_toPS is don't-care while fifo_empty=1, and a bench does not check it.
REQ-020 Occupancy update: push only -> +1; pop only -> -1; both accepted -> unchanged.
REQ-021 Full with push and pop in the same cycle: both are accepted and fifo_full stays 1.
REQ-022 Empty with push and pop in the same cycle: the pop is rejected, the push is accepted, and count becomes 1.
REQ-023 A push while full without a pop is dropped, and memory and pointers are unchanged.
REQ-024 A pop while empty is ignored, and pointers are unchanged.
REQ-025 fifo_full, fifo_empty, fifo_afull and count are registered or derived only from registered state, with no combinational path from push or pop.
REQ-026 flush=1 zeroes both pointers and count on the next edge, takes priority over push and pop in that cycle, and does not clear the sticky flags.

Reset
REQ-027 reset=1 on an edge sets wr_ptr=0, rd_ptr=0, count=0, fifo_empty=1, fifo_full=0, fifo_afull=0, overflow=0 and underflow=0.
REQ-028 Reset has priority over flush, push and pop; storage contents are not cleared.
REQ-029 Reset mid-transfer discards all contents, and the FIFO accepts a push on the first edge after reset deasserts.

Configuration
REQ-030 With macro SD_DAT_FIFO_ERR_FLAGS_EN defined, overflow sets on any dropped push (REQ-023), underflow sets on any ignored pop (REQ-024), and both stay set until reset.
REQ-031 Without SD_DAT_FIFO_ERR_FLAGS_EN, the overflow and underflow ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-032 Package sd_dat_pkg holds DAT_W=32, default FIFO_DEPTH=8 and a typedef dat_word_t (logic [DAT_W-1:0]), shared with the DAT P/S and S/P stages.
REQ-033 Storage is a sub-module, sd_dat_fifo_mem: a DEPTH x 32 register file with one synchronous write port and one asynchronous read port; pointers and flags stay in sd_dat_fifo.

Verification
REQ-034 Fill/drain:
- Stimulus: after reset, push 8 words 0xC0000003, 0xC000E000, ... on consecutive cycles, then pop 8 times.
- Response: fifo_full=1 after the 8th push; words emerge in order; fifo_empty=1 after the 8th pop.
REQ-035 Afull: push 6 words -> fifo_afull rises on the edge after the 6th push, and count=6.
REQ-036 Full push+pop:
- Stimulus: while full, push 0xDEADBEEF with pop in the same cycle.
- Response: count stays 8; head advances; 0xDEADBEEF is read 8th.
REQ-037 Error cases:
- Push while full with no pop -> count stays 8 and overflow=1 (macro defined).
- Pop while empty -> underflow=1, pointers unchanged.
REQ-038 Flush and reset mid-operation:
- With 3 words stored, flush=1 together with push=1 -> count=0 and fifo_empty=1 next cycle.
- Repeating this with reset instead gives the same result.
REQ-039 Wrap: run 20 push/pop pairs with distinct data at occupancy 2 -> read order matches write order across pointer wrap.
